// File: rtl/vga_axil_pkg.sv
// Shared AXI4-Lite types and helpers for the VGA register slave.
package vga_axil_pkg;

   localparam int AXIL_ADDR_W = 32;
   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_STRB_W = 4;

   typedef logic [AXIL_ADDR_W-1:0] axil_addr_t;
   typedef logic [AXIL_DATA_W-1:0] axil_data_t;
   typedef logic [AXIL_STRB_W-1:0] axil_strb_t;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } axil_resp_e;

   // Byte-lane merge: lane k takes new_v only where strb[k] is set.
   function automatic axil_data_t merge_strb(input axil_data_t old_v,
                                             input axil_data_t new_v,
                                             input axil_strb_t strb);
      axil_data_t res;
      res = old_v;
      for (int k = 0; k < AXIL_STRB_W; k++) begin
         if (strb[k]) begin
            res[8*k +: 8] = new_v[8*k +: 8];
         end else begin
            res[8*k +: 8] = old_v[8*k +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_axil_reg_bank.sv
// Register storage: one byte-enabled write port, one combinational read port.
module vga_axil_reg_bank
   import vga_axil_pkg::*;
#(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
)(
   input  logic             clk,
   input  logic             arst_n,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  axil_data_t       wdata,
   input  axil_strb_t       wstrb,
   input  logic [IDX_W-1:0] ridx,
   output axil_data_t       rdata,
   output axil_data_t       regs_o [NUM_REGS]
);

   axil_data_t regs_r [NUM_REGS];

   // Storage update with per-byte enables.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_r[i] <= 32'h0000_0000;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (we && (widx == IDX_W'(i))) begin
               regs_r[i] <= merge_strb(regs_r[i], wdata, wstrb);
            end
         end
      end
   end

   // AND-OR read mux so out-of-range indices read as zero.
   always_comb begin
      rdata = 32'h0000_0000;
      for (int i = 0; i < NUM_REGS; i++) begin
         rdata = rdata | ({AXIL_DATA_W{ridx == IDX_W'(i)}} & regs_r[i]);
      end
   end

   assign regs_o = regs_r;

endmodule

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave exposing NUM_REGS control registers to the VGA core.
module vga_axil_slave
   import vga_axil_pkg::*;
#(
   parameter int NUM_REGS = 4
)(
   input  logic                   clk,
   input  logic                   arst_n,
   input  axil_addr_t             awaddr,
   input  logic                   awvalid,
   output logic                   awready,
   input  axil_data_t             wdata,
   input  logic [AXIL_STRB_W-1:0] wstrb,
   input  logic                   wvalid,
   output logic                   wready,
   output axil_resp_e             bresp,
   output logic                   bvalid,
   input  logic                   bready,
   input  axil_addr_t             araddr,
   input  logic                   arvalid,
   output logic                   arready,
   output axil_data_t             rdata,
   output axil_resp_e             rresp,
   output logic                   rvalid,
   input  logic                   rready,
   output axil_data_t             regs_o [NUM_REGS]
);

   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int WIDX_W = AXIL_ADDR_W - 2;
   localparam logic [WIDX_W-1:0] REG_LIMIT = WIDX_W'(NUM_REGS);

   logic              ready_en_r;
   logic              aw_full_r;
   logic [WIDX_W-1:0] aw_idx_r;
   logic              w_full_r;
   axil_data_t        w_data_r;
   axil_strb_t        w_strb_r;
   logic              bvalid_r;
   axil_resp_e        bresp_r;
   logic              rvalid_r;
   axil_data_t        rdata_r;
   axil_resp_e        rresp_r;

   logic              aw_hs_s;
   logic              w_hs_s;
   logic              ar_hs_s;
   logic              commit_s;
   logic              aw_in_range_s;
   logic              ar_in_range_s;
   logic [WIDX_W-1:0] ar_idx_s;
   axil_data_t        bank_rdata_s;
   logic              unused_s;

   // Byte-offset bits carry no meaning for word registers.
   assign unused_s      = ^{awaddr[1:0], araddr[1:0]};

   assign ar_idx_s      = araddr[AXIL_ADDR_W-1:2];
   assign aw_in_range_s = (aw_idx_r < REG_LIMIT);
   assign ar_in_range_s = (ar_idx_s < REG_LIMIT);

   assign awready  = ready_en_r && !aw_full_r;
   assign wready   = ready_en_r && !w_full_r;
   assign arready  = ready_en_r && (!rvalid_r || rready);
   assign aw_hs_s  = awvalid && awready;
   assign w_hs_s   = wvalid && wready;
   assign ar_hs_s  = arvalid && arready;
   // A pending B response blocks the next commit until it is accepted.
   assign commit_s = aw_full_r && w_full_r && !bvalid_r;

   assign bvalid = bvalid_r;
   assign bresp  = bresp_r;
   assign rvalid = rvalid_r;
   assign rdata  = rdata_r;
   assign rresp  = rresp_r;

   // Hold the ready outputs low until the first edge after reset release.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
      end
   end

   // Independent AW and W slots, both freed when the write commits.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         aw_full_r <= 1'b0;
         aw_idx_r  <= {WIDX_W{1'b0}};
         w_full_r  <= 1'b0;
         w_data_r  <= 32'h0000_0000;
         w_strb_r  <= 4'h0;
      end else begin
         if (commit_s) begin
            aw_full_r <= 1'b0;
         end else if (aw_hs_s) begin
            aw_full_r <= 1'b1;
            aw_idx_r  <= awaddr[AXIL_ADDR_W-1:2];
         end
         if (commit_s) begin
            w_full_r <= 1'b0;
         end else if (w_hs_s) begin
            w_full_r <= 1'b1;
            w_data_r <= wdata;
            w_strb_r <= wstrb;
         end
      end
   end

   // Write response channel.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         bvalid_r <= 1'b0;
         bresp_r  <= OKAY;
      end else if (commit_s) begin
         bvalid_r <= 1'b1;
         bresp_r  <= aw_in_range_s ? OKAY : SLVERR;
      end else if (bvalid_r && bready) begin
         bvalid_r <= 1'b0;
      end
   end

   // Read data channel; sampling the bank here yields the pre-write value on a collision.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0000_0000;
         rresp_r  <= OKAY;
      end else if (ar_hs_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= ar_in_range_s ? bank_rdata_s : 32'h0000_0000;
         rresp_r  <= ar_in_range_s ? OKAY : SLVERR;
      end else if (rvalid_r && rready) begin
         rvalid_r <= 1'b0;
      end
   end

   vga_axil_reg_bank #(
      .NUM_REGS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_reg_bank (
      .clk    (clk),
      .arst_n (arst_n),
      .we     (commit_s && aw_in_range_s),
      .widx   (aw_idx_r[IDX_W-1:0]),
      .wdata  (w_data_r),
      .wstrb  (w_strb_r),
      .ridx   (ar_idx_s[IDX_W-1:0]),
      .rdata  (bank_rdata_s),
      .regs_o (regs_o)
   );

endmodule

// File: tb/tb_vga_axil_slave.sv
// Directed and randomized bench for vga_axil_slave against a register-array model.
module tb_vga_axil_slave;
   import vga_axil_pkg::*;

   localparam int NUM_REGS = 4;

   logic       clk = 1'b0;
   logic       arst_n;
   axil_addr_t awaddr;
   logic       awvalid;
   logic       awready;
   axil_data_t wdata;
   axil_strb_t wstrb;
   logic       wvalid;
   logic       wready;
   axil_resp_e bresp;
   logic       bvalid;
   logic       bready;
   axil_addr_t araddr;
   logic       arvalid;
   logic       arready;
   axil_data_t rdata;
   axil_resp_e rresp;
   logic       rvalid;
   logic       rready;
   axil_data_t regs_o [NUM_REGS];

   int         n_assert = 0;
   int         n_fail   = 0;
   axil_data_t model [NUM_REGS];

   always #5 clk = ~clk;

   vga_axil_slave #(.NUM_REGS(NUM_REGS)) dut (
      .clk(clk), .arst_n(arst_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .regs_o(regs_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NUM_REGS; i++) begin
         chk($sformatf("%s_reg%0d", tag, i), regs_o[i], model[i]);
      end
   endtask

   // Reference: AXI-Lite byte-strobed write into an array of NUM_REGS words.
   task automatic model_wr(input axil_addr_t a, input axil_data_t d, input axil_strb_t s,
                           output axil_resp_e er);
      int unsigned idx;
      idx = a / 4;
      if (idx < NUM_REGS) begin
         for (int k = 0; k < 4; k++) begin
            if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
         end
         er = OKAY;
      end else begin
         er = SLVERR;
      end
   endtask

   task automatic model_rd(input axil_addr_t a, output axil_data_t ed, output axil_resp_e er);
      int unsigned idx;
      idx = a / 4;
      if (idx < NUM_REGS) begin
         ed = model[idx];
         er = OKAY;
      end else begin
         ed = 32'h0;
         er = SLVERR;
      end
   endtask

   task automatic send(input axil_addr_t a, input axil_data_t d, input axil_strb_t s,
                       input bit do_aw, input bit do_w);
      logic aw_go, w_go;
      awaddr = a; wdata = d; wstrb = s; awvalid = do_aw; wvalid = do_w;
      for (int i = 0; i < 30 && (awvalid || wvalid); i++) begin
         @(negedge clk);
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_go) awvalid = 1'b0;
         if (w_go)  wvalid  = 1'b0;
      end
      chk("aw_w_handshake_timeout", {31'b0, awvalid | wvalid}, 32'h0);
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic wait_b(output axil_resp_e r, output int lat);
      bit got;
      got = 1'b0; lat = -1; r = OKAY;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (bvalid) begin got = 1'b1; r = bresp; lat = i; end
      end
      @(posedge clk); #1;
      chk("b_timeout", {31'b0, got}, 32'h1);
   endtask

   task automatic do_read(input axil_addr_t a, output axil_data_t d, output axil_resp_e r,
                          output int lat);
      logic go;
      bit   got;
      araddr = a; arvalid = 1'b1;
      for (int i = 0; i < 30 && arvalid; i++) begin
         @(negedge clk);
         go = arready;
         @(posedge clk); #1;
         if (go) arvalid = 1'b0;
      end
      chk("ar_timeout", {31'b0, arvalid}, 32'h0);
      arvalid = 1'b0;
      got = 1'b0; lat = -1; d = 32'h0; r = OKAY;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (rvalid) begin got = 1'b1; d = rdata; r = rresp; lat = i; end
      end
      @(posedge clk); #1;
      chk("r_timeout", {31'b0, got}, 32'h1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      axil_resp_e r, er;
      axil_data_t d, ed, held_d, old1;
      axil_resp_e held_r;
      axil_addr_t a;
      axil_strb_t s;
      int         lat;
      bit         bad;
      int unsigned mode;

      awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
      araddr = 32'h0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;

      // Reset state
      arst_n = 1'b0;
      #12;
      chk("rst_awready", {31'b0, awready}, 32'h0);
      chk("rst_wready",  {31'b0, wready},  32'h0);
      chk("rst_arready", {31'b0, arready}, 32'h0);
      chk("rst_bvalid",  {31'b0, bvalid},  32'h0);
      chk("rst_rvalid",  {31'b0, rvalid},  32'h0);
      chk("rst_rdata",   rdata, 32'h0);
      chk("rst_bresp",   32'(bresp), 32'(OKAY));
      chk("rst_rresp",   32'(rresp), 32'(OKAY));
      check_regs("rst");
      @(posedge clk); #1;
      arst_n = 1'b1;
      chk("rel_awready_before_edge", {31'b0, awready}, 32'h0);
      @(posedge clk); #1;
      chk("rel_awready", {31'b0, awready}, 32'h1);
      chk("rel_wready",  {31'b0, wready},  32'h1);
      chk("rel_arready", {31'b0, arready}, 32'h1);

      // Basic write then read of word 1
      send(32'h4, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
      model_wr(32'h4, 32'hDEADBEEF, 4'hF, er);
      wait_b(r, lat);
      chk("w1_bresp", 32'(r), 32'(OKAY));
      chk("w1_blat", 32'(lat), 32'd1);
      do_read(32'h4, d, r, lat);
      chk("r1_rdata", d, 32'hDEADBEEF);
      chk("r1_rresp", 32'(r), 32'(OKAY));
      chk("r1_rlat", 32'(lat), 32'd0);
      chk("r1_regs1", regs_o[1], 32'hDEADBEEF);

      // W arrives three cycles ahead of AW
      send(32'h0, 32'h12345678, 4'hF, 1'b0, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bvalid || wready || !awready) bad = 1'b1;
      end
      @(posedge clk); #1;
      chk("wfirst_no_early_b", {31'b0, bad}, 32'h0);
      send(32'h0, 32'h12345678, 4'hF, 1'b1, 1'b0);
      model_wr(32'h0, 32'h12345678, 4'hF, er);
      wait_b(r, lat);
      chk("wfirst_bresp", 32'(r), 32'(OKAY));
      chk("wfirst_blat", 32'(lat), 32'd1);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bvalid) bad = 1'b1;
      end
      chk("wfirst_single_b", {31'b0, bad}, 32'h0);
      chk("wfirst_regs0", regs_o[0], 32'h12345678);

      // Byte strobes
      send(32'h8, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
      model_wr(32'h8, 32'hFFFFFFFF, 4'hF, er);
      wait_b(r, lat);
      send(32'h8, 32'h000000AA, 4'h1, 1'b1, 1'b1);
      model_wr(32'h8, 32'h000000AA, 4'h1, er);
      wait_b(r, lat);
      chk("strb_bresp", 32'(r), 32'(OKAY));
      chk("strb_regs2", regs_o[2], 32'hFFFFFFAA);
      send(32'hE, 32'h55555555, 4'h0, 1'b1, 1'b1);
      wait_b(r, lat);
      chk("strb0_bresp", 32'(r), 32'(OKAY));
      check_regs("strb0");

      // Out-of-range and low-address-bit handling
      send(32'h10, 32'hA5A5A5A5, 4'hF, 1'b1, 1'b1);
      wait_b(r, lat);
      chk("oor_bresp", 32'(r), 32'(SLVERR));
      check_regs("oor");
      do_read(32'h10, d, r, lat);
      chk("oor_rdata", d, 32'h0);
      chk("oor_rresp", 32'(r), 32'(SLVERR));
      send(32'h7, 32'h0000BEEF, 4'h3, 1'b1, 1'b1);
      model_wr(32'h7, 32'h0000BEEF, 4'h3, er);
      wait_b(r, lat);
      chk("lowbits_regs1", regs_o[1], 32'hDEADBEEF);

      // Read and write to the same register commit together
      old1 = model[1];
      awaddr = 32'h4; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      @(negedge clk);
      chk("coll_aw_w_ready", {30'b0, awready, wready}, 32'h3);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0; araddr = 32'h4; arvalid = 1'b1;
      @(negedge clk);
      chk("coll_arready", {31'b0, arready}, 32'h1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      chk("coll_rdata_prewrite", rdata, old1);
      chk("coll_bvalid", {31'b0, bvalid}, 32'h1);
      model_wr(32'h4, 32'h01020304, 4'hF, er);
      chk("coll_regs1", regs_o[1], 32'h01020304);
      @(posedge clk); #1;

      // Back-pressure on B: hold stable, block the next commit
      bready = 1'b0;
      send(32'hC, 32'hCAFEF00D, 4'hF, 1'b1, 1'b1);
      model_wr(32'hC, 32'hCAFEF00D, 4'hF, er);
      bad = 1'b1;
      for (int i = 0; i < 10 && bad; i++) begin
         @(negedge clk);
         if (bvalid) bad = 1'b0;
      end
      chk("bp_bvalid_seen", {31'b0, bad}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!bvalid || bresp !== OKAY) bad = 1'b1;
      end
      chk("bp_b_stable", {31'b0, bad}, 32'h0);
      @(posedge clk); #1;
      send(32'h0, 32'h0BADCAFE, 4'hF, 1'b1, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (!bvalid || regs_o[0] !== model[0]) bad = 1'b1;
      end
      chk("bp_second_blocked", {31'b0, bad}, 32'h0);
      check_regs("bp_first");
      @(posedge clk); #1;
      bready = 1'b1;
      @(posedge clk); #1;
      wait_b(r, lat);
      model_wr(32'h0, 32'h0BADCAFE, 4'hF, er);
      chk("bp_second_bresp", 32'(r), 32'(OKAY));
      chk("bp_second_blat", 32'(lat), 32'd1);
      check_regs("bp_second");

      // Back-pressure on R
      rready = 1'b0;
      do_read(32'hC, held_d, held_r, lat);
      chk("rbp_rdata", held_d, 32'hCAFEF00D);
      bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!rvalid || rdata !== held_d || rresp !== held_r || arready) bad = 1'b1;
      end
      chk("rbp_r_stable", {31'b0, bad}, 32'h0);
      @(posedge clk); #1;
      rready = 1'b1;
      @(negedge clk);
      chk("rbp_arready_on_accept", {31'b0, arready}, 32'h1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rbp_rvalid_cleared", {31'b0, rvalid}, 32'h0);
      @(posedge clk); #1;

      // Reset mid-transaction
      send(32'h4, 32'h11111111, 4'hF, 1'b1, 1'b0);
      rready = 1'b0;
      do_read(32'h0, d, r, lat);
      arst_n = 1'b0;
      #2;
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
      chk("mrst_ready", {29'b0, awready, wready, arready}, 32'h0);
      chk("mrst_valid", {30'b0, bvalid, rvalid}, 32'h0);
      chk("mrst_rdata", rdata, 32'h0);
      chk("mrst_resp", {28'b0, bresp, rresp}, 32'h0);
      check_regs("mrst");
      @(posedge clk); @(posedge clk); #1;
      arst_n = 1'b1;
      rready = 1'b1;
      @(posedge clk); #1;
      send(32'h8, 32'h22222222, 4'hF, 1'b0, 1'b1);
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bvalid || rvalid) bad = 1'b1;
      end
      chk("mrst_no_stale_resp", {31'b0, bad}, 32'h0);
      @(posedge clk); #1;
      send(32'h4, 32'h22222222, 4'hF, 1'b1, 1'b0);
      model_wr(32'h4, 32'h22222222, 4'hF, er);
      wait_b(r, lat);
      chk("mrst_after_bresp", 32'(r), 32'(OKAY));
      check_regs("mrst_after");

      // Randomized traffic against the model
      for (int n = 0; n < 40; n++) begin
         a    = 32'($urandom_range(0, 23));
         d    = $urandom;
         s    = 4'($urandom_range(0, 15));
         mode = $urandom_range(0, 2);
         if (mode == 0) begin
            send(a, d, s, 1'b1, 1'b1);
         end else if (mode == 1) begin
            send(a, d, s, 1'b0, 1'b1);
            send(a, d, s, 1'b1, 1'b0);
         end else begin
            send(a, d, s, 1'b1, 1'b0);
            send(a, d, s, 1'b0, 1'b1);
         end
         model_wr(a, d, s, er);
         wait_b(r, lat);
         chk($sformatf("rnd%0d_bresp", n), 32'(r), 32'(er));
         check_regs($sformatf("rnd%0d", n));
         a = 32'($urandom_range(0, 23));
         model_rd(a, ed, er);
         do_read(a, d, r, lat);
         chk($sformatf("rnd%0d_rdata", n), d, ed);
         chk($sformatf("rnd%0d_rresp", n), 32'(r), 32'(er));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_axil_slave.md
VGA_AXIL_SLAVE -- requirements
Module: vga_axil_slave

Interface
REQ-001 SHALL have parameter NUM_REGS, default 4, number of 32-bit read/write registers at word addresses 0x0..(NUM_REGS-1)*4.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port arst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have ports awaddr input axil_addr_t, awvalid input 1, awready output 1; write-address channel.
REQ-005 SHALL have ports wdata input axil_data_t, wstrb input 4, wvalid input 1, wready output 1; write-data channel.
REQ-006 SHALL have ports bresp output axil_resp_e, bvalid output 1, bready input 1; write-response channel.
REQ-007 SHALL have ports araddr input axil_addr_t, arvalid input 1, arready output 1; read-address channel.
REQ-008 SHALL have ports rdata output axil_data_t, rresp output axil_resp_e, rvalid output 1, rready input 1; read-data channel.
REQ-009 SHALL have port regs_o, output, NUM_REGS x axil_data_t, current register contents to the VGA core.

Function
REQ-010 SHALL latch AW and W independently: awready=1 while AW slot empty, wready=1 while W slot empty; each slot fills on its own valid&&ready.
REQ-011 SHALL perform the write in the cycle after both slots are full and no B response is pending, then assert bvalid the following edge and free both slots.
REQ-012 SHALL accept AW and W in the same cycle; write and bvalid follow with minimum latency 1 cycle after the handshake.
REQ-013 SHALL hold bvalid and bresp stable until bready; slots may refill while bvalid=1, but no new write commits until the B handshake completes.
REQ-014 SHALL decode word index = awaddr[..:2]; awaddr[1:0] ignored.
REQ-015 SHALL apply wstrb per byte: byte k updated only when wstrb[k]=1; wstrb=0 writes nothing and still returns OKAY.
REQ-016 SHALL return bresp=SLVERR and leave all registers unchanged when index >= NUM_REGS; OKAY otherwise.
REQ-017 SHALL drive arready=1 when rvalid=0 or (rvalid&&rready); on AR handshake, rvalid=1 with rdata/rresp on the next edge (1-cycle latency).
REQ-018 SHALL return rdata=0, rresp=SLVERR for index >= NUM_REGS; register value, OKAY otherwise.
REQ-019 SHALL hold rvalid, rdata, rresp stable until rready; back-to-back reads at 1 per cycle when rready held high.
REQ-020 SHALL return the pre-write value when a read and a write commit to the same register in the same cycle.
REQ-021 SHALL update regs_o the edge after a write commits.

Reset
REQ-022 SHALL, on arst_n=0, asynchronously clear all registers to 0, both slots to empty, bvalid=0, rvalid=0, bresp=OKAY, rresp=OKAY, rdata=0.
REQ-023 SHALL drive awready=wready=arready=0 while arst_n=0 and raise them on the first clk edge after release.
REQ-024 SHALL discard any in-flight transaction (latched slot or pending B/R) when reset asserts mid-operation; no response issued afterwards.

Structure
REQ-025 SHALL take axil_addr_t (32b), axil_data_t (32b), axil_resp_e (OKAY, SLVERR) from vga_axil_pkg; add AXIL_STRB_W=4 constant there.
REQ-026 SHALL split storage into sub-module vga_axil_reg_bank (write port with byte enables, combinational read port, regs_o); handshake logic stays in vga_axil_slave.

Verification
REQ-027 Reset released, write addr 0x4 data 0xDEADBEEF wstrb 0xF, bready=1 -> bresp=OKAY, then read 0x4 -> rdata=0xDEADBEEF, rresp=OKAY, regs_o[1]=0xDEADBEEF.
REQ-028 W sent 3 cycles before AW (addr 0x0, data 0x12345678) -> single B OKAY only after AW; regs_o[0]=0x12345678.
REQ-029 Reg 2=0xFFFFFFFF, write 0x8 data 0x000000AA wstrb 0x1 -> regs_o[2]=0xFFFFFFAA.
REQ-030 Write/read addr 0x10 (NUM_REGS=4) -> bresp=SLVERR, rresp=SLVERR, rdata=0, all regs unchanged.
REQ-031 bready=0 for 5 cycles after write -> bvalid, bresp stable; rready=0 likewise holds rdata; second write not committed until B handshake.
REQ-032 arst_n pulsed low with AW latched and rvalid=1 -> all outputs at reset values, regs_o=0, no B/R response after release.
